// File: rtl/game_pkg.sv
// Shared definitions for the game session controller and the display/image mux.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GEN       = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_RESULT    = 3'd4,
        ST_GAME_OVER = 3'd5
    } session_state_t;

    localparam int unsigned IMG_IDLE      = 0;
    localparam int unsigned IMG_PAUSED    = 1;
    localparam int unsigned IMG_GAME_OVER = 2;
    localparam int unsigned IMG_GEN       = 3;
    localparam int unsigned IMG_WIN       = 4;
    localparam int unsigned IMG_LOSE      = 5;

endpackage

// File: rtl/btn_rise_detect.sv
// Registered rising-edge detector for a bank of level button inputs.
module btn_rise_detect #(
    parameter int unsigned CHANNELS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] rise
);

    logic [CHANNELS-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= btn;
            rise <= btn & ~prev;
        end
    end

endmodule

// File: rtl/game_session_ctrl.sv
// Game-flow controller: generate -> run -> result -> next level with lives,
// score, high score, level/difficulty tracking and generation-timeout retries.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int unsigned RATING_WIDTH    = 8,
    parameter int unsigned NUM_LIVES       = 3,
    parameter int unsigned NUM_IMAGES      = 8,
    parameter int unsigned RESULT_CYCLES   = 4,
    parameter int unsigned GEN_TIMEOUT     = 16,
    parameter int unsigned LEVELS_PER_STEP = 4,
    parameter int unsigned DIFF_WIDTH      = 2,
    parameter int unsigned LIVES_W         = $clog2(NUM_LIVES + 1),
    parameter int unsigned IMG_W           = $clog2(NUM_IMAGES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_is_win,
    input  logic                    i_round_ended,
    input  logic                    i_ready,
    input  logic                    i_pause_game,
    input  logic                    i_start_game,
    output logic                    o_regenerate_level,
    output logic                    o_game_running,
    output logic [RATING_WIDTH-1:0] o_current_rating,
    output logic [RATING_WIDTH-1:0] o_high_score,
    output logic                    o_new_record,
    output logic [LIVES_W-1:0]      o_lives,
    output logic [RATING_WIDTH-1:0] o_level,
    output logic [DIFF_WIDTH-1:0]   o_difficulty,
    output logic                    o_image_valid,
    output logic [IMG_W-1:0]        o_image_number
);

    localparam int unsigned TMR_MAX = (RESULT_CYCLES > GEN_TIMEOUT) ? RESULT_CYCLES : GEN_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] GEN_LAST = TMR_W'(GEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RES_LAST = TMR_W'(RESULT_CYCLES - 1);
    localparam int unsigned STEP_SH = $clog2(LEVELS_PER_STEP);
    localparam logic [RATING_WIDTH-1:0] DIFF_MAX = RATING_WIDTH'((1 << DIFF_WIDTH) - 1);

    session_state_t          state;
    logic [TMR_W-1:0]        timer;
    logic                    result_win;
    logic [1:0]              btn_rise;
    logic                    start_rise;
    logic                    pause_rise;
    logic [RATING_WIDTH-1:0] level_step;

    btn_rise_detect #(.CHANNELS(2)) u_btn_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   ({i_pause_game, i_start_game}),
        .rise  (btn_rise)
    );

    assign start_rise = btn_rise[0];
    assign pause_rise = btn_rise[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            timer              <= '0;
            result_win         <= 1'b0;
            o_regenerate_level <= 1'b0;
            o_current_rating   <= '0;
            o_high_score       <= '0;
            o_new_record       <= 1'b0;
            o_lives            <= LIVES_W'(NUM_LIVES);
            o_level            <= '0;
        end else begin
            o_regenerate_level <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start_rise) begin
                        state              <= ST_GEN;
                        timer              <= '0;
                        o_regenerate_level <= 1'b1;
                        o_current_rating   <= '0;
                        o_level            <= '0;
                        o_lives            <= LIVES_W'(NUM_LIVES);
                        o_new_record       <= 1'b0;
                    end
                end
                ST_GEN: begin
                    if (i_ready) begin
                        state <= ST_RUN;
                        timer <= '0;
                    end else if (timer == GEN_LAST) begin
                        timer              <= '0;
                        o_regenerate_level <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Round end outranks a pause edge arriving in the same cycle.
                    if (i_round_ended) begin
                        state      <= ST_RESULT;
                        timer      <= '0;
                        result_win <= i_is_win;
                        if (i_is_win) begin
                            if (o_current_rating != '1) o_current_rating <= o_current_rating + 1'b1;
                            if (o_level != '1)          o_level          <= o_level + 1'b1;
                        end else if (o_lives != '0) begin
                            o_lives <= o_lives - 1'b1;
                        end
                    end else if (pause_rise) begin
                        state <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start_rise) state <= ST_RUN;
                end
                ST_RESULT: begin
                    if (timer == RES_LAST) begin
                        timer <= '0;
                        if (result_win || o_lives != '0) begin
                            state              <= ST_GEN;
                            o_regenerate_level <= 1'b1;
                        end else begin
                            state <= ST_GAME_OVER;
                            if (o_current_rating > o_high_score) begin
                                o_high_score <= o_current_rating;
                                o_new_record <= 1'b1;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign o_game_running = (state == ST_RUN);

    always_comb begin
        level_step   = o_level >> STEP_SH;
        o_difficulty = (level_step > DIFF_MAX) ? '1 : level_step[DIFF_WIDTH-1:0];
    end

    always_comb begin
        o_image_valid  = 1'b1;
        o_image_number = '0;
        case (state)
            ST_IDLE:      o_image_number = IMG_W'(IMG_IDLE);
            ST_PAUSED:    o_image_number = IMG_W'(IMG_PAUSED);
            ST_GAME_OVER: o_image_number = IMG_W'(IMG_GAME_OVER);
            ST_GEN:       o_image_number = IMG_W'(IMG_GEN);
            ST_RESULT:    o_image_number = result_win ? IMG_W'(IMG_WIN) : IMG_W'(IMG_LOSE);
            ST_RUN:       o_image_valid  = 1'b0;
            default:      o_image_number = '0;
        endcase
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Randomized self-checking bench for game_session_ctrl against a round-level game model.
module tb_game_session_ctrl;

    localparam int unsigned NL   = 3;
    localparam int unsigned RC   = 4;
    localparam int unsigned GT   = 16;
    localparam int unsigned LPS  = 4;
    localparam int unsigned SMAX = 255;
    localparam int unsigned DMAX = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       is_win = 1'b0;
    logic       round_ended = 1'b0;
    logic       ready = 1'b0;
    logic       pause = 1'b0;
    logic       start = 1'b0;
    logic       regen;
    logic       running;
    logic [7:0] score;
    logic [7:0] high;
    logic       new_rec;
    logic [1:0] lives;
    logic [7:0] level;
    logic [1:0] diff;
    logic       img_valid;
    logic [2:0] img_num;

    game_session_ctrl #(
        .RATING_WIDTH(8), .NUM_LIVES(NL), .NUM_IMAGES(8), .RESULT_CYCLES(RC),
        .GEN_TIMEOUT(GT), .LEVELS_PER_STEP(LPS), .DIFF_WIDTH(2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_is_win           (is_win),
        .i_round_ended      (round_ended),
        .i_ready            (ready),
        .i_pause_game       (pause),
        .i_start_game       (start),
        .o_regenerate_level (regen),
        .o_game_running     (running),
        .o_current_rating   (score),
        .o_high_score       (high),
        .o_new_record       (new_rec),
        .o_lives            (lives),
        .o_level            (level),
        .o_difficulty       (diff),
        .o_image_valid      (img_valid),
        .o_image_number     (img_num)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned m_score, m_level, m_lives, m_high, m_rec;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_regs(input string tag);
        int unsigned d;
        d = m_level / LPS;
        if (d > DMAX) d = DMAX;
        check({tag, "_score"}, 32'(score), m_score);
        check({tag, "_level"}, 32'(level), m_level);
        check({tag, "_lives"}, 32'(lives), m_lives);
        check({tag, "_diff"},  32'(diff),  d);
        check({tag, "_high"},  32'(high),  m_high);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 0; pause = 0; ready = 0; round_ended = 0; is_win = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_score = 0; m_level = 0; m_lives = NL; m_high = 0; m_rec = 0;
        tick();
        check_regs("reset");
        check("reset_regen", 32'(regen), 0);
        check("reset_rec", 32'(new_rec), 0);
        check("reset_running", 32'(running), 0);
        check("reset_img", 32'({img_valid, img_num}), 32'h8);
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("regen_before_edge", 32'(regen), 0);
        tick();
        m_score = 0; m_level = 0; m_lives = NL; m_rec = 0;
        check("newgame_regen", 32'(regen), 1);
        check("newgame_img", 32'({img_valid, img_num}), 32'h8 | 3);
        check("newgame_rec", 32'(new_rec), 0);
        check_regs("newgame");
    endtask

    // Sits in GEN (already past the entry cycle) for dly cycles, then supplies i_ready.
    task automatic gen_phase(input int unsigned dly);
        int unsigned pulses = 0;
        int unsigned consec = 0;
        bit prev = 1'b1;
        for (int unsigned i = 0; i < dly; i++) begin
            tick();
            if (regen) pulses++;
            if (regen && prev) consec++;
            prev = regen;
        end
        check("gen_retry_pulses", pulses, dly / GT);
        check("regen_consecutive", consec, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("run_entry_running", 32'(running), 1);
        check("run_entry_imgvalid", 32'(img_valid), 0);
    endtask

    task automatic run_round(input bit win, input int unsigned wait_cyc, input bit do_pause,
                             input bit simul, input bit stray, output bit over);
        int unsigned n;
        int unsigned exp_img;
        for (int unsigned i = 0; i < wait_cyc; i++) begin
            if (stray) ready = 1'($urandom_range(0, 1));
            tick();
            check("run_hold", 32'(running), 1);
        end
        ready = 1'b0;
        if (do_pause) begin
            pause = 1'b1; tick(); pause = 1'b0; tick();
            check("paused_img", 32'({img_valid, img_num}), 32'h8 | 1);
            check("paused_running", 32'(running), 0);
            round_ended = 1'b1; is_win = 1'($urandom_range(0, 1));
            tick();
            round_ended = 1'b0;
            check("paused_ignore_end", 32'({img_valid, img_num}), 32'h8 | 1);
            check_regs("paused");
            pause = 1'b1; tick(); pause = 1'b0; tick();
            check("paused_ignore_pause", 32'({img_valid, img_num}), 32'h8 | 1);
            start = 1'b1; tick(); start = 1'b0; tick();
            check("resume_running", 32'(running), 1);
        end
        if (simul) begin
            pause = 1'b1; tick(); pause = 1'b0;
        end
        round_ended = 1'b1; is_win = win;
        tick();
        round_ended = 1'b0; is_win = 1'b0;
        if (win) begin
            if (m_score < SMAX) m_score++;
            if (m_level < SMAX) m_level++;
        end else begin
            m_lives--;
        end
        exp_img = win ? 4 : 5;
        check_regs("result");
        n = 0;
        while (img_valid && 32'(img_num) == exp_img && n < 20) begin
            n++;
            tick();
        end
        check("result_len", n, RC);
        over = (!win && m_lives == 0);
        if (!over) begin
            check("post_result_regen", 32'(regen), 1);
            check("post_result_img", 32'({img_valid, img_num}), 32'h8 | 3);
        end else begin
            if (m_score > m_high) begin
                m_high = m_score;
                m_rec = 1;
            end
            check("gameover_img", 32'({img_valid, img_num}), 32'h8 | 2);
            check("gameover_rec", 32'(new_rec), m_rec);
            check("gameover_regen", 32'(regen), 0);
            check_regs("gameover");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit over;
        int unsigned rounds;
        do_reset();

        new_game();
        gen_phase(3);

        for (int i = 0; i < 5; i++) begin
            run_round(1'b1, 2, 1'b0, 1'b0, 1'b0, over);
            gen_phase(1);
        end
        check("five_wins_diff", 32'(diff), 1);

        for (int i = 0; i < 3; i++) begin
            run_round(1'b0, 1, 1'b0, 1'b0, 1'b0, over);
            if (!over) gen_phase(2);
        end
        check("three_losses_over", 32'(over), 1);

        new_game();
        gen_phase(40);

        run_round(1'b0, 1, 1'b0, 1'b1, 1'b0, over);
        gen_phase(0);
        run_round(1'b1, 2, 1'b1, 1'b0, 1'b0, over);
        gen_phase(5);

        for (int g = 0; g < 3; g++) begin
            rounds = 0;
            over = 1'b0;
            while (!over && rounds < 60) begin
                run_round(1'($urandom_range(0, 1)), $urandom_range(0, 6),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 1'b1, over);
                if (!over) gen_phase($urandom_range(0, 35));
                rounds++;
            end
            if (over) begin
                new_game();
                gen_phase($urandom_range(0, 20));
            end
        end

        run_round(1'b1, 3, 1'b0, 1'b0, 1'b0, over);
        do_reset();

        new_game();
        gen_phase(0);
        for (int i = 0; i < 256; i++) begin
            run_round(1'b1, 0, 1'b0, 1'b0, 1'b0, over);
            gen_phase(0);
        end
        check("sat_score", 32'(score), SMAX);
        check("sat_level", 32'(level), SMAX);
        check("sat_diff", 32'(diff), DMAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
